mdu_div: RTL

- Iterative restoring divider for MIPS DIV/DIVU.
- Sits directly upstream of the HI/LO register block: produces the div_hi value (remainder) and the div_lo value (quotient).
- The HI/LO block holds pc_ena low while busy is high, stalling the single-cycle datapath until done.
- Operands come from the register-file read ports (rdata1 = dividend, rdata2 = divisor).

---
 rtl/mdu_pkg.sv | 25 ++
 rtl/div_step.sv | 24 ++
 rtl/mdu_div.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared types and constants for the MIPS multiply/divide unit.
// MDU_DIV_2BIT_EN selects two restoring steps per divider cycle.
package mdu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int MDU_WIDTH = 32;

`ifdef MDU_DIV_2BIT_EN
  localparam int DIV_STEPS_PER_CYCLE = 2;
`else
  localparam int DIV_STEPS_PER_CYCLE = 1;
`endif

  localparam int DIV_ITERATIONS = MDU_WIDTH / DIV_STEPS_PER_CYCLE;

  // Divide-by-zero result: quotient all ones, remainder is the raw dividend.
  localparam logic [MDU_WIDTH-1:0] DIV0_QUOTIENT = '1;
  localparam logic                 DIV0_FLAG     = 1'b1;

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift {rem,quo} left, trial-subtract the divisor.
// Latency: combinational. Backpressure: none.
// Requires rem_in < divisor so the kept remainder always fits in WIDTH bits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // WIDTH+1 bits so the borrow of the trial subtraction is visible in the MSB.
  assign shifted = {rem_in, quo_in[WIDTH-1]};
  assign diff    = shifted - {1'b0, divisor};

  assign rem_out = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_out = {quo_in[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/mdu_div.sv
// Iterative restoring divider for DIV/DIVU; quotient feeds LO, remainder feeds HI.
// Latency: WIDTH/steps-per-cycle RUN cycles then a one-cycle done; divide-by-zero done next cycle.
// Backpressure: none; start is only sampled in IDLE, busy stalls the core. MDU_DIV_2BIT_EN doubles steps.
module mdu_div
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int ITERS = WIDTH / DIV_STEPS_PER_CYCLE;
  localparam int CW    = $clog2(ITERS);
  localparam logic [CW-1:0] LAST_COUNT = CW'(ITERS - 1);

  div_state_t       state, state_nxt;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic             sign_q, sign_r;
  logic [CW-1:0]    count;
  logic             last_iter;

  assign last_iter = (count == LAST_COUNT);

`ifdef MDU_DIV_2BIT_EN
  logic [WIDTH-1:0] rem_mid, quo_mid;

  div_step #(.WIDTH(WIDTH)) u_step0 (
    .rem_in(rem_q), .quo_in(quo_q), .divisor(dvs_q),
    .rem_out(rem_mid), .quo_out(quo_mid)
  );
  div_step #(.WIDTH(WIDTH)) u_step1 (
    .rem_in(rem_mid), .quo_in(quo_mid), .divisor(dvs_q),
    .rem_out(rem_nxt), .quo_out(quo_nxt)
  );
`else
  div_step #(.WIDTH(WIDTH)) u_step0 (
    .rem_in(rem_q), .quo_in(quo_q), .divisor(dvs_q),
    .rem_out(rem_nxt), .quo_out(quo_nxt)
  );
`endif

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (divisor == '0) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_iter) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quotient    <= {WIDTH{DIV0_QUOTIENT[0]}};
              remainder   <= dividend;
              div_by_zero <= DIV0_FLAG;
            end else begin
              // Magnitudes stay unsigned: |-2^(WIDTH-1)| is representable in WIDTH bits.
              quo_q       <= (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
              dvs_q       <= (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
              rem_q       <= '0;
              count       <= '0;
              sign_q      <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              sign_r      <= is_signed & dividend[WIDTH-1];
              div_by_zero <= 1'b0;
            end
          end
        end
        RUN: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          count <= count + 1'b1;
          if (last_iter) begin
            quotient  <= sign_q ? -quo_nxt : quo_nxt;
            remainder <= sign_r ? -rem_nxt : rem_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
